// File: rtl/aes_uart_pkg.sv
//==============================================================================
// Module : aes_uart_pkg
// Brief  : Shared command bytes, FSM state encoding and frame geometry for the
//          UART-fronted AES sequencer.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package aes_uart_pkg;

  localparam int unsigned c_frame_bytes = 18;
  localparam int unsigned c_frame_w     = c_frame_bytes * 8;
  localparam int unsigned c_block_w     = 128;

  localparam logic [7:0] c_cmd_a = 8'h41;
  localparam logic [7:0] c_cmd_b = 8'h42;
  localparam logic [7:0] c_cmd_c = 8'h43;
  localparam logic [7:0] c_cmd_d = 8'h44;
  localparam logic [7:0] c_cmd_e = 8'h45;
  localparam logic [7:0] c_cmd_n = 8'h4E;

  // Identification reply, first character in the header byte
  localparam logic [c_frame_w-1:0] c_id_reply = "123456789012345678";

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_REPLY  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ERR   = 3'd0,
    OP_REPLY = 3'd1,
    OP_KEY   = 3'd2,
    OP_TEXT  = 3'd3,
    OP_ENC   = 3'd4
  } op_t;

endpackage

`default_nettype wire

// File: rtl/aes_uart_frame_codec.sv
//==============================================================================
// Module : aes_uart_frame_codec
// Brief  : Classifies a received frame and builds the matching reply frame.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_uart_frame_codec
  import aes_uart_pkg::*;
#(
  parameter int unsigned FRAME_W = c_frame_w
) (
  input  logic [FRAME_W-1:0]   i_frame,
  input  logic [c_block_w-1:0] i_result,
  input  logic                 i_result_valid,
  output op_t                  o_op,
  output logic [c_block_w-1:0] o_payload,
  output logic [FRAME_W-1:0]   o_reply
);

  logic [7:0] w_hdr;
  logic [7:0] w_trl;

  assign w_hdr     = i_frame[FRAME_W-1 -: 8];
  assign w_trl     = i_frame[7:0];
  assign o_payload = i_frame[8 +: c_block_w];

  // A header/trailer mismatch is treated as a corrupted frame
  always_comb begin
    o_op    = OP_ERR;
    o_reply = '0;
    if (w_hdr == w_trl) begin
      case (w_hdr)
        c_cmd_a: begin
          o_op    = OP_REPLY;
          o_reply = FRAME_W'(c_id_reply);
        end
        c_cmd_b: begin
          o_op = OP_REPLY;
          if (i_result_valid) begin
            o_reply[FRAME_W-1 -: 8]  = c_cmd_b;
            o_reply[8 +: c_block_w]  = i_result;
            o_reply[7:0]             = c_cmd_b;
          end else begin
            o_reply[FRAME_W-1 -: 8]  = c_cmd_n;
            o_reply[7:0]             = c_cmd_n;
          end
        end
        c_cmd_c: o_op = OP_KEY;
        c_cmd_d: o_op = OP_TEXT;
        c_cmd_e: o_op = OP_ENC;
        default: o_op = OP_ERR;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_uart_sequencer.sv
//==============================================================================
// Module : aes_uart_sequencer
// Brief  : Sequences UART command frames into AES key/text loads, encryption
//          runs with timeout, and reply transmission.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_uart_sequencer
  import aes_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FRAME_BYTES    = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FRAME_BYTES*8-1:0] frame_in,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic [c_block_w-1:0]     aes_key,
  output logic [c_block_w-1:0]     aes_text_in,
  output logic                     aes_ld,
  input  logic                     aes_done,
  input  logic [c_block_w-1:0]     aes_text_out,
  output logic [FRAME_BYTES*8-1:0] tx_frame,
  output logic                     tx_send,
  input  logic                     tx_busy,
  output logic                     result_valid,
  output logic [7:0]               err_cnt
);

  localparam int unsigned c_fw    = FRAME_BYTES * 8;
  localparam int unsigned c_tmo_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

  state_t               r_state;
  state_t               w_next;
  logic                 w_err_inc;
  logic [c_fw-1:0]      r_frame;
  logic [c_block_w-1:0] r_key;
  logic [c_block_w-1:0] r_text;
  logic [c_block_w-1:0] r_result;
  logic                 r_result_valid;
  logic [c_fw-1:0]      r_tx_frame;
  logic                 r_tx_send;
  logic [7:0]           r_err_cnt;
  logic [c_tmo_w-1:0]   r_tmo_cnt;

  op_t                  w_op;
  logic [c_block_w-1:0] w_payload;
  logic [c_fw-1:0]      w_reply;

  aes_uart_frame_codec #(
    .FRAME_W (c_fw)
  ) u_codec (
    .i_frame        (r_frame),
    .i_result       (r_result),
    .i_result_valid (r_result_valid),
    .o_op           (w_op),
    .o_payload      (w_payload),
    .o_reply        (w_reply)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_err_inc   = 1'b0;
    frame_ready = 1'b0;
    aes_ld      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        frame_ready = ~reset;
        if (frame_valid && !reset) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (w_op)
          OP_REPLY: w_next = ST_REPLY;
          OP_ENC:   w_next = ST_LOAD;
          OP_KEY,
          OP_TEXT:  w_next = ST_IDLE;
          default: begin
            w_err_inc = 1'b1;
            w_next    = ST_IDLE;
          end
        endcase
      end
      ST_LOAD: begin
        aes_ld = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (aes_done) begin
          w_next = ST_IDLE;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_err_inc = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_REPLY: begin
        if (!tx_busy) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame        <= '0;
      r_key          <= '0;
      r_text         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_tx_frame     <= '0;
      r_tx_send      <= 1'b0;
      r_err_cnt      <= 8'd0;
      r_tmo_cnt      <= '0;
    end else begin
      r_tx_send <= 1'b0;
      if (frame_valid && frame_ready) r_frame <= frame_in;
      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      case (r_state)
        ST_DECODE: begin
          case (w_op)
            OP_KEY:   r_key          <= w_payload;
            OP_TEXT:  r_text         <= w_payload;
            OP_ENC:   r_result_valid <= 1'b0;
            OP_REPLY: r_tx_frame     <= w_reply;
            default: ;
          endcase
        end
        ST_LOAD: r_tmo_cnt <= '0;
        ST_WAIT: begin
          r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
          if (aes_done) begin
            r_result       <= aes_text_out;
            r_result_valid <= 1'b1;
          end
        end
        // Trigger lands on the cycle after the transmitter frees up
        ST_REPLY: if (!tx_busy) r_tx_send <= 1'b1;
        default: ;
      endcase
    end
  end

  assign aes_key      = r_key;
  assign aes_text_in  = r_text;
  assign tx_frame     = r_tx_frame;
  assign tx_send      = r_tx_send;
  assign result_valid = r_result_valid;
  assign err_cnt      = r_err_cnt;

endmodule

`default_nettype wire
